// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round-loop controller.
// The slot record mirrors one stage of the reg1/reg2/reg3 ring.
package aes_ctrl_pkg;

  localparam int unsigned TAG_W      = 4;
  localparam int unsigned LOOP_DEPTH = 3;
  localparam int unsigned NR_AES128  = 10;
  localparam int unsigned NR_AES192  = 12;
  localparam int unsigned NR_AES256  = 14;
  localparam int unsigned KEY_IDX_W  = 4;

  typedef struct packed {
    logic                 v;
    logic [3:0]           round;
    logic [TAG_W-1:0]     tag;
  } slot_t;

  // True when a block in this round leaves the loop through the final ARK.
  function automatic logic is_last_round(input logic [3:0] round, input int unsigned nr);
    return round == 4'(nr - 1);
  endfunction

endpackage

// File: rtl/aes_round_scheduler.sv
// Scheduler for the 3-register iterative AES loop: tracks one block per stage,
// drives mux select, round-key index, pipeline enable and ciphertext capture.
module aes_round_scheduler
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NR = NR_AES128
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 key_valid,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 mux_sel,
  output logic                 pipe_en,
  output logic [KEY_IDX_W-1:0] ark_key_idx,
  output logic                 cap_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  slot_t            s1_q, s2_q, s3_q;
  slot_t            s1_d, s2_d, s3_d;
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             retire_s;
  logic             inject_s;

  // A full result register with no taker freezes the whole ring, not just S3.
  always_comb begin
    retire_s    = s3_q.v && is_last_round(s3_q.round, NR);
    pipe_en     = !(retire_s && out_valid_q && !out_ready);
    in_ready    = key_valid && pipe_en && (!s3_q.v || retire_s);
    inject_s    = in_valid && in_ready;
    mux_sel     = !inject_s;
    ark_key_idx = s1_q.v ? s1_q.round : 4'd0;
    cap_en      = retire_s && pipe_en;
    busy        = s1_q.v | s2_q.v | s3_q.v | out_valid_q;
    out_valid   = out_valid_q;
    out_tag     = out_tag_q;
  end

  // Next state of the slot ring: S3 feeds back into S1 unless retiring or overridden by an inject.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (pipe_en) begin
      s2_d = s1_q;
      s3_d = s2_q;
      if (inject_s) begin
        s1_d = '{v: 1'b1, round: 4'd0, tag: in_tag};
      end else if (s3_q.v && !retire_s) begin
        s1_d = '{v: 1'b1, round: s3_q.round + 4'd1, tag: s3_q.tag};
      end else begin
        s1_d = '0;
      end
    end else begin
      s1_d = s1_q;
      s2_d = s2_q;
      s3_d = s3_q;
    end
  end

  // Result holding register; a capture wins over a same-cycle pop.
  always_comb begin
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    if (cap_en) begin
      out_valid_d = 1'b1;
      out_tag_d   = s3_q.tag;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Randomized bench for aes_round_scheduler: an age-based reference model
// predicts every output each cycle; a monitor checks popped tags against a queue.
module tb_aes_round_scheduler;
  import aes_ctrl_pkg::*;

  localparam int NR = 10;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 key_valid = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [TAG_W-1:0]     in_tag = '0;
  logic                 mux_sel;
  logic                 pipe_en;
  logic [KEY_IDX_W-1:0] ark_key_idx;
  logic                 cap_en;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [TAG_W-1:0]     out_tag;
  logic                 busy;

  aes_round_scheduler #(.NR(NR)) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .mux_sel(mux_sel), .pipe_en(pipe_en), .ark_key_idx(ark_key_idx),
    .cap_en(cap_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: each in-flight block is a count of cycles until its capture.
  int               rem[$];
  logic [TAG_W-1:0] btag[$];
  logic             m_ov   = 1'b0;
  logic [TAG_W-1:0] m_otag = '0;
  logic [TAG_W-1:0] exp_tags[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [TAG_W-1:0] tg, input logic kv,
                      input logic ordy, input logic rn);
    int   due_i;
    int   s1_round;
    logic s3_busy, retire, freeze, e_rdy, inj, cap;
    @(negedge clk);
    in_valid  = iv;
    in_tag    = tg;
    key_valid = kv;
    out_ready = ordy;
    reset_n   = rn;
    #1;
    if (!rn) begin
      rem.delete();
      btag.delete();
      exp_tags.delete();
      m_ov   = 1'b0;
      m_otag = '0;
    end else begin
      due_i    = -1;
      s1_round = -1;
      s3_busy  = 1'b0;
      foreach (rem[i]) begin
        if (rem[i] == 0) due_i = i;
        if (rem[i] > 0 && rem[i] % 3 == 0) s3_busy = 1'b1;
        if (rem[i] % 3 == 2) s1_round = (3 * NR - 1 - rem[i]) / 3;
      end
      retire = (due_i >= 0);
      freeze = retire && m_ov && !ordy;
      e_rdy  = kv && !freeze && !s3_busy;
      inj    = iv && e_rdy;
      cap    = retire && !freeze;

      chk("in_ready", int'(in_ready), int'(e_rdy));
      chk("pipe_en", int'(pipe_en), int'(!freeze));
      chk("cap_en", int'(cap_en), int'(cap));
      chk("mux_sel", int'(mux_sel), int'(!inj));
      chk("ark_key_idx", int'(ark_key_idx), (s1_round >= 0) ? s1_round : 0);
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (m_ov) chk("out_tag", int'(out_tag), int'(m_otag));
      chk("busy", int'(busy), int'(rem.size() > 0 || m_ov));

      if (cap) begin
        m_otag = btag[due_i];
        m_ov   = 1'b1;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (!freeze) begin
        if (due_i >= 0) begin
          rem.delete(due_i);
          btag.delete(due_i);
        end
        foreach (rem[i]) rem[i] = rem[i] - 1;
      end
      if (inj) begin
        rem.push_back(3 * NR - 1);
        btag.push_back(tg);
        exp_tags.push_back(tg);
      end
    end
  endtask

  // Monitor: every handshake at the result port must deliver the oldest accepted tag.
  initial begin
    logic [TAG_W-1:0] t;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && out_valid && out_ready) begin
        if (exp_tags.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          t = exp_tags.pop_front();
          chk("pop_tag", int'(out_tag), int'(t));
        end
      end
    end
  end

  initial begin
    int drain;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Single block, tag 5.
    step(1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3 * NR + 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Three back-to-back blocks; the sink stalls while tag 2 retires.
    for (int i = 1; i <= 3; i++) step(1'b1, TAG_W'(i), 1'b1, 1'b1, 1'b1);
    for (int i = 3; i < 3 * NR; i++) step(1'b1, 4'd9, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // key_valid low blocks injection, then restored.
    for (int i = 0; i < 4; i++) step(1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
    step(1'b1, 4'd8, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    // Reset with two blocks in flight.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 60, TAG_W'($urandom), $urandom_range(0, 99) < 90,
           $urandom_range(0, 99) < 70, $urandom_range(0, 999) != 0);
    end

    // Drain with a bounded budget.
    drain = 0;
    while ((rem.size() > 0 || m_ov) && drain < 200) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      drain++;
    end
    chk("drain_timeout", int'(drain >= 200), 0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("final_busy", int'(busy), 0);
    chk("final_queue", exp_tags.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_scheduler.md
Name: aes_round_scheduler

Overview:
- Controller for the iterative 3-register AES-128 encryption loop: input mux, reg1, ARK, reg2, SubBytes/ShiftRows, reg3, MixColumns back to the mux, with a final ARK tap at reg3.
- Interleaves up to 3 independent blocks, one per pipeline stage.
- Tracks round and tag per stage; drives the mux select, round-key index, pipeline enable and ciphertext capture enable.
- Presents valid/ready handshakes to the block source and the result sink.

Parameters:
- NR, 10: AES rounds. The key store must supply keys 0..NR. Legal values 10, 12, 14.
- TAG_W, 4: width of the user tag carried with each block.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- key_valid  in  1  round-key store holds a valid expanded key; no injection while low
- in_valid  in  1  new plaintext is presented on the datapath mux input
- in_ready  out  1  block accepted this cycle when in_valid && in_ready
- in_tag  in  TAG_W  tag of the offered block
- mux_sel  out  1  0 = plaintext into reg1, 1 = MixColumns feedback
- pipe_en  out  1  common load enable for reg1/reg2/reg3
- ark_key_idx  out  4  round-key index for the ARK after reg1
- cap_en  out  1  load enable for the ciphertext register (final ARK, key NR)
- out_valid  out  1  ciphertext register holds an unread result
- out_ready  in  1  sink accepts the result
- out_tag  out  TAG_W  tag of the held result
- busy  out  1  any stage occupied or out_valid high

Behaviour:
- State: slots S1, S2, S3 aligned with reg1, reg2, reg3 outputs. Each slot holds {v, round[3:0], tag}.
- Outputs with the following names are combinational from state and inputs:
  - retire = S3.v && S3.round == NR-1
  - pipe_en = !(retire && out_valid && !out_ready)
  - in_ready = key_valid && pipe_en && (!S3.v || retire)
  - inject = in_valid && in_ready
  - mux_sel = !inject
  - ark_key_idx = S1.v ? S1.round : 0
  - cap_en = retire && pipe_en
  - busy = S1.v | S2.v | S3.v | out_valid
- On a clock edge with pipe_en high:
  - S2 <= S1; S3 <= S2.
  - S1 <= inject ? {1, 0, in_tag} : (S3.v && !retire) ? {1, S3.round+1, S3.tag} : invalid.
- pipe_en low: all slots hold their values.
- Output register:
  - cap_en sets out_valid and loads out_tag <= S3.tag.
  - A pop (out_valid && out_ready) without a same-cycle cap_en clears out_valid.
  - A pop and cap_en in the same cycle leave out_valid at 1 with the new tag.
- Latency:
  - Block accepted in cycle t: S1 in cycle t+1+3r for round r.
  - Retire (cap_en) in cycle t+3NR (t+30 for NR=10); out_valid high from t+3NR+1.
- Throughput:
  - Up to 3 blocks in flight.
  - A retiring slot may be refilled by an inject in the same cycle.
- Stall: if a retire finds out_valid high and out_ready low, the whole loop freezes.
  - in_ready is 0 during the freeze.
  - The freeze releases the cycle out_ready rises; the retire and the pop happen together.
- key_valid falling mid-operation blocks new injects only. In-flight blocks complete. The key store must not change keys while busy.
- Reset (synchronous, reset_n low at an edge, including mid-operation): all slot v = 0, round = 0, tags = 0, out_valid = 0, out_tag = 0.
  - Resulting outputs: mux_sel 1 unless in_valid && key_valid, pipe_en 1, cap_en 0, busy 0, ark_key_idx 0.
  - In-flight blocks are discarded with no cap_en.
- Round counter never exceeds NR-1; a slot at NR-1 always leaves at S3.

Decomposition:
- Package aes_ctrl_pkg holds:
  - slot_t struct {logic v; logic [3:0] round; logic [TAG_W-1:0] tag} (TAG_W via package parameter)
  - LOOP_DEPTH = 3
  - NR_AES128/192/256 = 10/12/14
  - KEY_IDX_W = 4
- No sub-module. The slot ring and output flag live in one module, sequential logic only for slots and output register.

Test Plan:
- Single block: reset, key_valid=1, inject tag 5 at cycle 0 with FIPS-197 plaintext 00112233445566778899aabbccddeeff and key 000102...0f.
  - ark_key_idx = 0..9 at cycles 1, 4, ..., 28; cap_en only at cycle 30.
  - out_valid at 31 with out_tag 5; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Three back-to-back injects, tags 1, 2, 3, at cycles 0-2.
  - in_ready low cycles 3-29.
  - Retire at 30, 31, 32 in tag order; 4th block injected at cycle 30.
- Backpressure: out_ready=0 when tag 2 retires at cycle 31 with tag 1 still held.
  - pipe_en=0 and slots frozen until out_ready=1.
  - Then tag 2 is captured in the same cycle as tag 1 is popped.
- key_valid=0 with in_valid=1: in_ready stays 0, no inject. Restore key_valid: inject the next cycle.
- reset_n low at cycle 12 with 2 blocks in flight: next cycle busy=0, no cap_en, out_valid=0.
- NR=14 build: single block retires at cycle 42 and ark_key_idx reaches 13.
